// File: rtl/regfile_pkg.sv
// Shared register-file definitions: sizes, write record and the round-robin pick function.
package regfile_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

  // First set bit of valid scanning upward from ptr, wrapping at n (n in 2..4, ptr < n).
  function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr,
                                         input logic [2:0] n);
    logic [1:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= n) idx = idx - n;
      if (3'(k) < n && !found && valid[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin requester pick with its rotating priority pointer.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            hold,
  output logic [NREQ-1:0] ready,
  output logic [1:0]      win,
  output logic            any
);

  logic [1:0] ptr;
  logic [3:0] vpad;
  logic       go;

  always_comb begin
    vpad             = '0;
    vpad[NREQ-1:0]   = valid;
  end

  assign any = |valid;
  assign win = rr_pick(vpad, ptr, 3'(NREQ));
  // ready is gated by rst_n so nothing looks accepted while the stage is held in reset.
  assign go  = any & ~hold & rst_n;

  always_comb begin
    ready = '0;
    for (int i = 0; i < NREQ; i++) ready[i] = go && (win == 2'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (any && !hold) ptr <= (win == 2'(NREQ-1)) ? 2'd0 : win + 2'd1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among NREQ requesters through one registered stage.
// Optional in-flight bitmap enabled by RFARB_SCOREBOARD_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               freeze,
  output logic               rf_regwrite,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_writedata,
  output logic [1:0]         grant_id,
  output logic [2**AW-1:0]   pending
);

  logic [1:0]    win;
  logic          any, accept, commit;
  logic [AW-1:0] rd_a   [4];
  logic [DW-1:0] data_a [4];

  logic          stage_v;
  logic [AW-1:0] stage_rd;
  logic [DW-1:0] stage_data;
  logic [1:0]    stage_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .hold  (freeze),
    .ready (req_ready),
    .win   (win),
    .any   (any)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_a[i]   = '0;
      data_a[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      rd_a[i]   = req_rd[i*AW +: AW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  assign accept = any & ~freeze;
  assign commit = stage_v & ~freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v    <= 1'b0;
      stage_rd   <= '0;
      stage_data <= '0;
      stage_id   <= '0;
    end else if (!freeze) begin
      stage_v <= any;
      if (any) begin
        stage_rd   <= rd_a[win];
        stage_data <= data_a[win];
        stage_id   <= win;
      end
    end
  end

  // x0 writes travel through the stage but never assert the enable.
  assign rf_regwrite  = commit & (stage_rd != '0);
  assign rf_rd        = stage_rd;
  assign rf_writedata = stage_data;
  assign grant_id     = stage_id;

`ifdef RFARB_SCOREBOARD_EN
  logic [2**AW-1:0] pend_q, pend_nxt;

  // Clear on commit first so a same-edge accept to the same register wins.
  always_comb begin
    pend_nxt = pend_q;
    if (commit) pend_nxt[stage_rd] = 1'b0;
    if (accept) pend_nxt[rd_a[win]] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end

  assign pending = pend_q;
`else
  assign pending = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change on negedge, outputs sampled 2ns later.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic               freeze;
  logic               rf_regwrite;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_writedata;
  logic [1:0]         grant_id;
  logic [31:0]        pending;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .freeze       (freeze),
    .rf_regwrite  (rf_regwrite),
    .rf_rd        (rf_rd),
    .rf_writedata (rf_writedata),
    .grant_id     (grant_id),
    .pending      (pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int i, input rf_wr_t w, input logic v);
    req_valid[i]          = v;
    req_rd[i*AW +: AW]    = w.rd;
    req_data[i*DW +: DW]  = w.data;
  endtask

  function automatic logic [31:0] exp_pend(input logic [31:0] m);
`ifdef RFARB_SCOREBOARD_EN
    return m;
`else
    return 32'h0 & m;
`endif
  endfunction

  rf_wr_t idle_w = '{rd: 5'd0, data: 32'h0};
  logic [4:0] seq [8] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};

  initial begin
    int c0, c1;
    rst_n     = 1'b0;
    freeze    = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    drv(0, '{rd: 5'd5, data: 32'h1}, 1'b1);

    // Reset state, with a request already waiting
    @(negedge clk); @(negedge clk);
    #2;
    chk("rst_regwrite", rf_regwrite, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_writedata, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_pending", pending, 0);

    // 1: single write, one-cycle latency
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, '{rd: 5'd5, data: 32'hA5A5_0001}, 1'b1);
    #2;
    chk("t1_ready0", req_ready, 2'b01);
    chk("t1_nowrite", rf_regwrite, 0);
    @(negedge clk);
    drv(0, idle_w, 1'b0);
    #2;
    chk("t1_regwrite", rf_regwrite, 1);
    chk("t1_rd", rf_rd, 5);
    chk("t1_data", rf_writedata, 32'hA5A5_0001);
    chk("t1_grant", grant_id, 0);
    chk("t1_pending", pending, exp_pend(32'h20));
    @(negedge clk);
    #2;
    chk("t1_drained", rf_regwrite, 0);
    chk("t1_pend_clr", pending, 0);

    // 3: x0 write from req1 (also rotates pointer back to req0)
    @(negedge clk);
    drv(1, '{rd: 5'd0, data: 32'hFFFF_FFFF}, 1'b1);
    #2;
    chk("t3_ready1", req_ready, 2'b10);
    chk("t3_pending_acc", pending, 0);
    @(negedge clk);
    drv(1, idle_w, 1'b0);
    #2;
    chk("t3_noregwrite", rf_regwrite, 0);
    chk("t3_grant", grant_id, 1);
    chk("t3_rd", rf_rd, 0);
    chk("t3_pending", pending, 0);

    // 2: both requesters busy, alternating grants
    c0 = 0;
    c1 = 0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      drv(0, '{rd: 5'(1 + c0), data: 32'hD000_0000 | (1 + c0)}, c0 < 4);
      drv(1, '{rd: 5'(9 + c1), data: 32'hD000_0000 | (9 + c1)}, c1 < 4);
      #2;
      if (c > 0) begin
        chk("t2_regwrite", rf_regwrite, 1);
        chk("t2_rd", rf_rd, seq[c-1]);
        chk("t2_data", rf_writedata, 32'hD000_0000 | 32'(seq[c-1]));
        chk("t2_grant", grant_id, 2'((c - 1) % 2));
      end
      if (c < 8) begin
        chk("t2_ready", req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
        if (c % 2 == 0) c0++;
        else            c1++;
      end
    end

    // 4: freeze holds stage rd=7 and blocks acceptance
    @(negedge clk);
    drv(0, '{rd: 5'd7, data: 32'h77}, 1'b1);
    #2;
    chk("t4_acc7", req_ready, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      freeze = 1'b1;
      drv(0, '{rd: 5'd6, data: 32'h66}, 1'b1);
      #2;
      chk("t4_frz_regwrite", rf_regwrite, 0);
      chk("t4_frz_ready", req_ready, 0);
      chk("t4_frz_rd", rf_rd, 7);
      chk("t4_frz_pending", pending, exp_pend(32'h80));
    end
    @(negedge clk);
    freeze = 1'b0;
    #2;
    chk("t4_commit7", rf_regwrite, 1);
    chk("t4_rd7", rf_rd, 7);
    chk("t4_data7", rf_writedata, 32'h77);
    chk("t4_ready0", req_ready, 2'b01);
    @(negedge clk);
    drv(0, idle_w, 1'b0);
    #2;
    chk("t4_commit6", rf_regwrite, 1);
    chk("t4_rd6", rf_rd, 6);
    chk("t4_data6", rf_writedata, 32'h66);

    // 5: back-to-back writes to rd=3, later grant wins, pending survives same-edge commit
    @(negedge clk);
    drv(0, '{rd: 5'd3, data: 32'h3A}, 1'b1);
    #2;
    chk("t5_readyA", req_ready, 2'b01);
    @(negedge clk);
    drv(0, idle_w, 1'b0);
    drv(1, '{rd: 5'd3, data: 32'h3B}, 1'b1);
    #2;
    chk("t5_readyB", req_ready, 2'b10);
    chk("t5_commitA", rf_writedata, 32'h3A);
    chk("t5_pendA", pending, exp_pend(32'h8));
    @(negedge clk);
    drv(1, idle_w, 1'b0);
    #2;
    chk("t5_commitB_we", rf_regwrite, 1);
    chk("t5_commitB", rf_writedata, 32'h3B);
    chk("t5_grantB", grant_id, 1);
    chk("t5_pendB", pending, exp_pend(32'h8));
    @(negedge clk);
    #2;
    chk("t5_idle", rf_regwrite, 0);
    chk("t5_pend_clr", pending, 0);

    // 6: reset while stage holds rd=8
    @(negedge clk);
    drv(0, '{rd: 5'd8, data: 32'h88}, 1'b1);
    #2;
    chk("t6_acc8", req_ready, 2'b01);
    @(negedge clk);
    drv(0, idle_w, 1'b0);
    #2;
    chk("t6_stage8", rf_rd, 8);
    chk("t6_stage8_we", rf_regwrite, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", rf_regwrite, 0);
    chk("t6_rst_rd", rf_rd, 0);
    chk("t6_rst_pend", pending, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, '{rd: 5'd13, data: 32'hD13}, 1'b1);
    drv(1, '{rd: 5'd14, data: 32'hD14}, 1'b1);
    #2;
    chk("t6_post_we", rf_regwrite, 0);
    chk("t6_post_ready", req_ready, 2'b01);
    @(negedge clk);
    drv(0, idle_w, 1'b0);
    drv(1, idle_w, 1'b0);
    #2;
    chk("t6_post_rd", rf_rd, 13);
    chk("t6_post_data", rf_writedata, 32'hD13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
